// File: rtl/multi_phase_traffic_ctrl.sv
// Multi-approach traffic light controller: GREEN -> YELLOW -> ALL_RED with round-robin demand service.
// Optional preemption ports and logic are built only when TRAFFIC_PREEMPT_EN is defined.
module multi_phase_traffic_ctrl #(
    parameter int unsigned N_PHASES = 4,
    parameter int unsigned G_MIN    = 5,
    parameter int unsigned G_MAX    = 20,
    parameter int unsigned Y_TIME   = 3,
    parameter int unsigned R_CLR    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_PHASES-1:0]           has_car,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic                          preempt_req,
    input  logic [$clog2(N_PHASES)-1:0]   preempt_phase,
`endif
    output logic [3*N_PHASES-1:0]         lights,
    output logic [$clog2(N_PHASES)-1:0]   cur_phase,
    output logic                          phase_start
);

    localparam int unsigned PW      = $clog2(N_PHASES);
    localparam int unsigned TMAX_GY = (G_MAX > Y_TIME) ? G_MAX : Y_TIME;
    localparam int unsigned TMAX    = (TMAX_GY > R_CLR) ? TMAX_GY : R_CLR;
    localparam int unsigned TW      = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_SAT  = TW'(TMAX);
    localparam logic [TW-1:0] T_GMIN = TW'(G_MIN - 1);
    localparam logic [TW-1:0] T_GMAX = TW'(G_MAX - 1);
    localparam logic [TW-1:0] T_YEL  = TW'(Y_TIME - 1);
    localparam logic [TW-1:0] T_RED  = TW'(R_CLR - 1);

    localparam logic [3*N_PHASES-1:0] RESET_LIGHTS = {{(N_PHASES-1){3'b100}}, 3'b001};

    typedef enum logic [1:0] {GREEN, YELLOW, ALL_RED} state_e;

    state_e                  state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [PW-1:0]           cur_q, cur_d;
    logic [PW-1:0]           next_q, next_d;
    logic [N_PHASES-1:0]     demand_q, demand_d;
    logic [3*N_PHASES-1:0]   lights_q, lights_d;
    logic                    pstart_q, pstart_d;

    logic [N_PHASES-1:0]     cur_onehot;
    logic                    others;
    logic [PW-1:0]           rr_pick;
    logic                    rr_found;
    logic                    go;
    logic [PW-1:0]           go_pick;

    assign cur_onehot = N_PHASES'(1) << cur_q;
    assign others     = |(demand_q & ~cur_onehot);

    always_comb begin
        rr_found = 1'b0;
        rr_pick  = cur_q;
        for (int unsigned k = 1; k < N_PHASES; k++) begin
            if (!rr_found && demand_q[(32'(cur_q) + k) % N_PHASES]) begin
                rr_found = 1'b1;
                rr_pick  = PW'((32'(cur_q) + k) % N_PHASES);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = (timer_q == T_SAT) ? timer_q : timer_q + 1'b1;
        cur_d    = cur_q;
        next_d   = next_q;
        go       = 1'b0;
        go_pick  = rr_pick;
        // The entering phase's latch is cleared on its first green cycle; a same-cycle set loses.
        demand_d = (demand_q | has_car) &
                   ~((state_q == GREEN && timer_q == '0) ? cur_onehot : '0);

        case (state_q)
            GREEN: begin
                // ">=" keeps the G_MAX limit effective once the timer has saturated.
                go = others && (timer_q >= T_GMIN) &&
                     (!has_car[cur_q] || timer_q >= T_GMAX);
`ifdef TRAFFIC_PREEMPT_EN
                if (preempt_req) begin
                    go      = (preempt_phase != cur_q);
                    go_pick = preempt_phase;
                end
`endif
                if (go) begin
                    state_d = YELLOW;
                    timer_d = '0;
                    next_d  = go_pick;
                end
            end
            YELLOW: begin
`ifdef TRAFFIC_PREEMPT_EN
                if (preempt_req) next_d = preempt_phase;
`endif
                if (timer_q == T_YEL) begin
                    state_d = ALL_RED;
                    timer_d = '0;
                end
            end
            ALL_RED: begin
`ifdef TRAFFIC_PREEMPT_EN
                if (preempt_req) next_d = preempt_phase;
`endif
                if (timer_q == T_RED) begin
                    state_d = GREEN;
                    timer_d = '0;
                    cur_d   = next_d;
                end
            end
            default: begin
                state_d = GREEN;
                timer_d = '0;
            end
        endcase

        lights_d = '0;
        for (int unsigned i = 0; i < N_PHASES; i++) begin
            lights_d[3*i +: 3] = 3'b100;
            if (cur_d == PW'(i)) begin
                if (state_d == GREEN)       lights_d[3*i +: 3] = 3'b001;
                else if (state_d == YELLOW) lights_d[3*i +: 3] = 3'b010;
            end
        end
        pstart_d = (state_d == GREEN) && (state_q == ALL_RED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= GREEN;
            timer_q  <= '0;
            cur_q    <= '0;
            next_q   <= '0;
            demand_q <= '0;
            lights_q <= RESET_LIGHTS;
            pstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cur_q    <= cur_d;
            next_q   <= next_d;
            demand_q <= demand_d;
            lights_q <= lights_d;
            pstart_q <= pstart_d;
        end
    end

    assign lights      = lights_q;
    assign cur_phase   = cur_q;
    assign phase_start = pstart_q;

endmodule

// File: tb/tb_multi_phase_traffic_ctrl.sv
// Bench for multi_phase_traffic_ctrl: directed scenarios plus random demand against a plan-queue model.
module tb_multi_phase_traffic_ctrl;

    localparam int N  = 4;
    localparam int PW = 2;
    localparam int GMIN = 5;
    localparam int GMAX = 20;
    localparam int YT = 3;
    localparam int RC = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    has_car;
    logic [3*N-1:0]  lights;
    logic [PW-1:0]   cur_phase;
    logic            phase_start;
`ifdef TRAFFIC_PREEMPT_EN
    logic            preempt_req;
    logic [PW-1:0]   preempt_phase;
`endif

    always #5 clk = ~clk;

    multi_phase_traffic_ctrl #(
        .N_PHASES(N), .G_MIN(GMIN), .G_MAX(GMAX), .Y_TIME(YT), .R_CLR(RC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .has_car(has_car),
`ifdef TRAFFIC_PREEMPT_EN
        .preempt_req(preempt_req),
        .preempt_phase(preempt_phase),
`endif
        .lights(lights),
        .cur_phase(cur_phase),
        .phase_start(phase_start)
    );

    // Model: the green phase, its age, and a queue of planned non-green cycles (1=yellow, 2=all-red).
    int           m_phase, m_age, m_next;
    int           m_plan[$];
    logic [N-1:0] m_dem;
    logic         m_ps;
    int           total = 0;
    int           bad = 0;

    function automatic logic [3*N-1:0] exp_lights();
        logic [3*N-1:0] l;
        int kind;
        kind = (m_plan.size() != 0) ? m_plan[0] : 0;
        for (int i = 0; i < N; i++) begin
            l[3*i +: 3] = 3'b100;
            if (i == m_phase)
                l[3*i +: 3] = (kind == 0) ? 3'b001 : (kind == 1) ? 3'b010 : 3'b100;
        end
        return l;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_age = 0; m_next = 0; m_dem = '0; m_ps = 1'b0;
        m_plan.delete();
    endtask

    task automatic model_adv(input logic [N-1:0] h, input logic r, input logic pr, input int pp);
        logic [N-1:0] dem_old;
        logic others, leave;
        int tgt, j;
        if (!r) begin
            model_reset();
            return;
        end
        dem_old = m_dem;
        m_ps = 1'b0;
        m_dem = dem_old | h;
        if (m_plan.size() == 0 && m_age == 0) m_dem[m_phase] = 1'b0;
        if (m_plan.size() == 0) begin
            others = 1'b0;
            tgt = m_phase;
            for (int k = N - 1; k >= 1; k--) begin
                j = (m_phase + k) % N;
                if (dem_old[j]) begin
                    others = 1'b1;
                    tgt = j;
                end
            end
            leave = others && (m_age >= GMIN - 1) && (!h[m_phase] || m_age >= GMAX - 1);
            if (pr) begin
                leave = (pp != m_phase);
                tgt = pp;
            end
            if (leave) begin
                m_next = tgt;
                repeat (YT) m_plan.push_back(1);
                repeat (RC) m_plan.push_back(2);
            end else begin
                m_age++;
            end
        end else begin
            if (pr) m_next = pp;
            void'(m_plan.pop_front());
            if (m_plan.size() == 0) begin
                m_phase = m_next;
                m_age = 0;
                m_ps = 1'b1;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] h, input logic r, input logic pr, input int pp);
        chk("lights", 32'(lights), 32'(exp_lights()));
        chk("cur_phase", 32'(cur_phase), m_phase);
        chk("phase_start", 32'(phase_start), 32'(m_ps));
        has_car = h;
        rst_n = r;
`ifdef TRAFFIC_PREEMPT_EN
        preempt_req = pr;
        preempt_phase = PW'(pp);
`endif
        model_adv(h, r, pr, pp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] h;
        logic pr;
        int pp;
        has_car = '0;
        rst_n = 1'b0;
`ifdef TRAFFIC_PREEMPT_EN
        preempt_req = 1'b0;
        preempt_phase = '0;
`endif
        model_reset();
        @(posedge clk);
        #1;

        // Reset held two cycles
        step('0, 1'b0, 1'b0, 0);
        chk("reset_lights", 32'(lights), 32'h924 + 32'h1 - 32'h4);
        chk("reset_phase", 32'(cur_phase), 0);

        // Idle for 100 cycles
        repeat (100) step('0, 1'b1, 1'b0, 0);
        chk("idle_lights", 32'(lights), 32'b100_100_100_001);

        // Minimum green: pulse approach 2 at reset release
        step('0, 1'b0, 1'b0, 0);
        step(4'b0100, 1'b1, 1'b0, 0);
        repeat (9) step('0, 1'b1, 1'b0, 0);
        chk("mingreen_phase", 32'(cur_phase), 2);
        chk("mingreen_start", 32'(phase_start), 1);
        chk("mingreen_lights", 32'(lights), 32'b100_001_100_100);

        // Reset in the middle of yellow abandons the pending phase
        step(4'b0010, 1'b1, 1'b0, 0);
        repeat (5) step('0, 1'b1, 1'b0, 0);
        chk("preyel_lights", 32'(lights), 32'b100_010_100_100);
        step('0, 1'b0, 1'b0, 0);
        chk("midyel_reset_lights", 32'(lights), 32'b100_100_100_001);
        chk("midyel_reset_phase", 32'(cur_phase), 0);

        // Extension and round-robin: approach 0 held, 1 and 3 pulsed
        step(4'b1011, 1'b1, 1'b0, 0);
        repeat (19) step(4'b0001, 1'b1, 1'b0, 0);
        chk("ext_yellow", 32'(lights), 32'b100_100_100_010);
        repeat (5) step(4'b0001, 1'b1, 1'b0, 0);
        chk("rr_phase1", 32'(cur_phase), 1);
        chk("rr_start1", 32'(phase_start), 1);
        repeat (10) step(4'b0001, 1'b1, 1'b0, 0);
        chk("rr_phase3", 32'(cur_phase), 3);
        chk("rr_start3", 32'(phase_start), 1);
        repeat (30) step('0, 1'b1, 1'b0, 0);

`ifdef TRAFFIC_PREEMPT_EN
        step('0, 1'b0, 1'b0, 0);
        step('0, 1'b1, 1'b0, 0);
        step('0, 1'b1, 1'b1, 3);
        chk("pre_yellow", 32'(lights), 32'b100_100_100_010);
        repeat (5) step('0, 1'b1, 1'b1, 3);
        chk("pre_phase3", 32'(cur_phase), 3);
        chk("pre_start", 32'(phase_start), 1);
        repeat (30) step(4'b0111, 1'b1, 1'b1, 3);
        chk("pre_hold", 32'(lights), 32'b001_100_100_100);
        repeat (10) step('0, 1'b1, 1'b0, 0);
`endif

        // Random demand with occasional resets
        repeat (3000) begin
            for (int i = 0; i < N; i++) h[i] = ($urandom_range(7) == 0);
            pr = 1'b0;
            pp = 0;
`ifdef TRAFFIC_PREEMPT_EN
            pr = ($urandom_range(15) == 0);
            pp = int'($urandom_range(N - 1));
`endif
            step(h, ($urandom_range(299) != 0), pr, pp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multi_phase_traffic_ctrl.md
MULTI_PHASE_TRAFFIC_CTRL -- requirements
Module: multi_phase_traffic_ctrl

Interface
REQ-001 The block SHALL have parameter N_PHASES, default 4, meaning number of conflicting approaches (legal range 2..8).
REQ-002 The block SHALL have parameter G_MIN, default 5, meaning minimum green duration in cycles (legal minimum 1).
REQ-003 The block SHALL have parameter G_MAX, default 20, meaning maximum green duration in cycles when another approach is waiting (legal: G_MAX >= G_MIN).
REQ-004 The block SHALL have parameter Y_TIME, default 3, meaning yellow duration in cycles (legal minimum 1).
REQ-005 The block SHALL have parameter R_CLR, default 2, meaning all-red clearance duration in cycles (legal minimum 1).
REQ-006 The block SHALL have input clk, 1 bit, meaning the clock.
REQ-007 The block SHALL have input rst_n, 1 bit, meaning the reset; rst_n is synchronous and active-low.
REQ-008 The block SHALL have input has_car, N_PHASES bits, meaning per-approach vehicle sensor (bit i = approach i).
REQ-009 The block SHALL have output lights, 3*N_PHASES bits, meaning a one-hot light per approach in bits [3i+2:3i] (RED=100, YEL=010, GRE=001).
REQ-010 The block SHALL have output cur_phase, clog2(N_PHASES) bits, meaning the approach currently owning green or yellow.
REQ-011 The block SHALL have output phase_start, 1 bit, meaning a one-cycle pulse on the first green cycle of any phase.

Function
REQ-012 The FSM SHALL have states GREEN, YELLOW, ALL_RED; a cycle timer SHALL be 0 on the first cycle of each state and increment each cycle, saturating at G_MAX.
REQ-013 Demand latch bit i SHALL set when has_car[i]=1 and SHALL clear on the cycle approach i enters GREEN; a set during the same cycle as the clear SHALL lose.
REQ-014 The transition GREEN to YELLOW SHALL occur when other demand exists AND timer >= G_MIN-1 AND (has_car[cur_phase]=0 OR timer = G_MAX-1).
REQ-015 With no other demand latched, GREEN SHALL hold indefinitely and lights SHALL not change.
REQ-016 On YELLOW entry, next phase SHALL be the first latched approach found round-robin from cur_phase+1 with wrap-around, and SHALL be registered and held until green.
REQ-017 YELLOW SHALL last exactly Y_TIME cycles, then ALL_RED exactly R_CLR cycles, then GREEN of the registered next phase.
REQ-018 Lights SHALL be: cur_phase GRE in GREEN and YEL in YELLOW, all approaches RED in ALL_RED, and non-current approaches always RED.
REQ-019 Outputs SHALL be registered; no approach SHALL ever show GRE or YEL concurrently with another approach.

Reset
REQ-020 While rst_n=0 at a clk edge: state SHALL be GREEN, cur_phase 0, timer 0, demand latches 0, phase_start 0; lights SHALL be approach 0 GRE and others RED.
REQ-021 Reset mid-YELLOW or mid-ALL_RED SHALL abandon the pending phase and return to approach 0 GREEN on the next cycle.

Configuration
REQ-022 With macro TRAFFIC_PREEMPT_EN defined, the block SHALL add input preempt_req (1 bit) and input preempt_phase (clog2(N_PHASES) bits).
REQ-023 Under TRAFFIC_PREEMPT_EN, if preempt_req=1 in GREEN with cur_phase != preempt_phase, the block SHALL go to YELLOW the next cycle, ignoring G_MIN.
REQ-024 Under TRAFFIC_PREEMPT_EN, preempt_req=1 in YELLOW or ALL_RED SHALL override the registered next phase to preempt_phase without shortening the Y_TIME or R_CLR durations.
REQ-025 Under TRAFFIC_PREEMPT_EN, the preempted phase SHALL hold GREEN while preempt_req=1 regardless of G_MAX, then resume normal rules.
REQ-026 Without TRAFFIC_PREEMPT_EN, the ports and preemption logic SHALL be absent, and behaviour SHALL be per REQ-012..021.

Verification
REQ-027 Reset scenario: hold rst_n=0 for 2 cycles -> lights = {RED,RED,RED,GRE} (approach 3..0), cur_phase=0, phase_start=0.
REQ-028 Idle scenario: has_car=0 for 100 cycles after reset -> approach 0 GRE throughout, no phase_start.
REQ-029 Minimum-green scenario: has_car[2] pulsed 1 cycle at reset release with has_car[0]=0 -> 5 GRE, 3 YEL, 2 all-RED cycles, then approach 2 GRE with phase_start=1 on cycle 10.
REQ-030 Extension and round-robin scenario: has_car[0] held high, has_car[1] and has_car[3] pulsed -> approach 0 green 20 cycles, then approach 1, then approach 3, with approach 2 skipped.
REQ-031 Preemption scenario (TRAFFIC_PREEMPT_EN): preempt_req=1 and preempt_phase=3 at cycle 1 of approach 0 green -> YEL next cycle, then approach 3 GRE after 3+2 cycles, held until preempt_req drops.
